// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: shared encodings and build defaults for the C64 system-RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c64_bus_pkg;

  localparam int C64_AW          = 16;
  localparam int C64_DW          = 8;
  localparam int C64_STEAL_DELAY = 3;

  // Who issued the RAM access in the previous clk; steers the read-return mux.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VIC  = 2'd2
  } owner_t;

  // Bus-steal FSM encoding.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_STEAL = 2'd2;

endpackage

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter: time-slices one synchronous RAM between the 6502 (PHI2) and VIC-II (PHI1/stolen PHI2).
// Latency: RAM address driven combinationally in the slot clk, read data returned in the following clk.
// Backpressure: CPU is throttled with cpu_ce (max 1 per 2 clk); during a bus steal CPU reads are frozen.
// Ports: clk/reset (async active-low); cpu_ab/cpu_do/cpu_we in, cpu_di/cpu_ce out;
//        vic_req/vic_ab/vic_steal_req in, vic_di/vic_valid/vic_aec out; ram_ab/ram_do/ram_we out, ram_di in.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int AW          = C64_AW,
  parameter int DW          = C64_DW,
  parameter int STEAL_DELAY = C64_STEAL_DELAY
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_ce,
  input  logic          vic_req,
  input  logic [AW-1:0] vic_ab,
  output logic [DW-1:0] vic_di,
  output logic          vic_valid,
  input  logic          vic_steal_req,
  output logic          vic_aec,
  output logic [AW-1:0] ram_ab,
  output logic [DW-1:0] ram_do,
  output logic          ram_we,
  input  logic [DW-1:0] ram_di
);

  localparam int CW = (STEAL_DELAY < 1) ? 1 : $clog2(STEAL_DELAY + 1);

  logic          phi;          // 0 = PHI1 (VIC), 1 = PHI2 (CPU unless stolen)
  logic [1:0]    state_q;
  logic [1:0]    slot_st;      // state in force for the current PHI2 slot
  logic [CW-1:0] steal_cnt;
  owner_t        owner_q;
  owner_t        owner_d;
  logic [DW-1:0] cpu_di_hold;
  logic [DW-1:0] vic_di_hold;
  logic          cpu_slot;
  logic          vic_slot;

  // The FSM is resolved at the start of each PHI2 slot, so a dropped steal
  // request or an expired grace count takes effect in that very slot.
  always_comb begin
    slot_st = ST_RUN;
    case (state_q)
      ST_WAIT: begin
        if (!vic_steal_req)         slot_st = ST_RUN;
        else if (steal_cnt == '0)   slot_st = ST_STEAL;
        else                        slot_st = ST_WAIT;
      end
      ST_STEAL: slot_st = vic_steal_req ? ST_STEAL : ST_RUN;
      default:  slot_st = ST_RUN;
    endcase
  end

  // Slot ownership. In WAIT only writes are let through so the CPU can finish
  // a read-modify-write sequence; a read simply stalls with no RAM access.
  always_comb begin
    cpu_slot = 1'b0;
    vic_slot = 1'b0;
    if (!phi) begin
      vic_slot = vic_req;
    end else begin
      case (slot_st)
        ST_RUN:   cpu_slot = 1'b1;
        ST_WAIT:  cpu_slot = cpu_we;
        ST_STEAL: vic_slot = vic_req;
        default:  cpu_slot = 1'b0;
      endcase
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_slot)      owner_d = OWN_CPU;
    else if (vic_slot) owner_d = OWN_VIC;
  end

  // RAM side is gated by reset so every output reads 0 while reset is held.
  assign ram_ab  = !reset   ? '0 :
                   cpu_slot ? cpu_ab :
                   vic_slot ? vic_ab : '0;
  assign ram_do  = (reset && cpu_slot) ? cpu_do : '0;
  assign ram_we  = reset && cpu_slot && cpu_we;
  // In PHI1 vic_aec reflects ownership of the PHI2 slot just completed.
  assign vic_aec = reset && (phi ? (slot_st == ST_STEAL) : (state_q == ST_STEAL));

  // Return mux: data for the previous clk's access.
  assign cpu_ce    = (owner_q == OWN_CPU);
  assign cpu_di    = cpu_ce ? ram_di : cpu_di_hold;
  assign vic_valid = (owner_q == OWN_VIC);
  assign vic_di    = vic_valid ? ram_di : vic_di_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phi         <= 1'b0;
      state_q     <= ST_RUN;
      steal_cnt   <= '0;
      owner_q     <= OWN_NONE;
      cpu_di_hold <= '0;
      vic_di_hold <= '0;
    end else begin
      phi     <= ~phi;
      owner_q <= owner_d;
      if (owner_q == OWN_CPU) cpu_di_hold <= ram_di;
      if (owner_q == OWN_VIC) vic_di_hold <= ram_di;
      if (phi) begin
        case (slot_st)
          ST_RUN: begin
            if (vic_steal_req) begin
              state_q   <= ST_WAIT;
              steal_cnt <= CW'(STEAL_DELAY);
            end else begin
              state_q   <= ST_RUN;
            end
          end
          ST_WAIT: begin
            // Grace slots are consumed whether or not the CPU used them.
            state_q   <= ST_WAIT;
            steal_cnt <= steal_cnt - CW'(1);
          end
          ST_STEAL: state_q <= ST_STEAL;
          default:  state_q <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: doc/c64_bus_arbiter.md
Name: c64_bus_arbiter

Overview:
- Shares the single-port synchronous system RAM (registered address, read data returned one clk later) between the 6502 core and the VIC-II fetch port.
- Splits time into alternating PHI1 (VIC) and PHI2 (CPU) slots, and gates CPU progress with a clock enable.
- Implements the VIC bus-steal sequence: a delayed handover of PHI2 slots while CPU writes complete.
- Sits between the CPU/VIC and the RAM in the C64 top level.

Parameters:
AW, 16, address width
DW, 8, data width
STEAL_DELAY, 3, CPU slots allowed (writes only) after a steal request before the VIC takes PHI2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_ab  in  AW  CPU address
cpu_do  in  DW  CPU write data
cpu_we  in  1  CPU write strobe
cpu_di  out  DW  CPU read data
cpu_ce  out  1  CPU clock enable; core advances only on clk edges where high
vic_req  in  1  VIC wants a read in the current VIC-usable slot
vic_ab  in  AW  VIC address
vic_di  out  DW  VIC read data
vic_valid  out  1  vic_di holds data for the previous VIC read
vic_steal_req  in  1  VIC requests PHI2 slots (badline/sprite)
vic_aec  out  1  high while the VIC owns PHI2 slots
ram_ab  out  AW  RAM address
ram_do  out  DW  RAM write data
ram_we  out  1  RAM write enable
ram_di  in  DW  RAM read data (for the address of the previous clk)

Behaviour:
- Reset (async, reset=0):
  - phi=0, state=RUN, steal_cnt=0, owner_q=NONE, cpu_di_hold=0.
  - All outputs 0.
  - A pending read is discarded; no strobe is emitted after release.
- phi toggles every clk; phi=0 is PHI1, phi=1 is PHI2.
- PHI1 slot:
  - If vic_req: ram_ab=vic_ab, ram_we=0, owner_q<=VIC.
  - Otherwise: ram_ab=0, ram_we=0, owner_q<=NONE.
- PHI2 slot, CPU granted:
  - ram_ab=cpu_ab, ram_do=cpu_do, ram_we=cpu_we; owner_q<=CPU.
- PHI2 slot, VIC owns (vic_aec=1):
  - ram_ab=vic_ab if vic_req, ram_we=0; owner_q<=VIC, or NONE if no vic_req.
- Read return (cycle after the slot):
  - owner_q==CPU: cpu_di=ram_di combinationally and cpu_ce=1 in that cycle; cpu_di_hold<=ram_di.
  - Otherwise cpu_di=cpu_di_hold. cpu_ce is high only in these cycles, so CPU rate is at most 1 per 2 clk.
  - owner_q==VIC: vic_di=ram_di, vic_valid=1; otherwise vic_valid=0 and vic_di holds its last value.
- Writes: cpu_ce=1 also follows a CPU write slot. RAM latency is 1 clk; a read issued in slot n is visible in n+1.
- FSM, evaluated at each PHI2 slot start:
  - RUN: CPU granted. If vic_steal_req=1, go to WAIT with steal_cnt=STEAL_DELAY; the current slot is still granted.
  - WAIT: a slot is granted only if cpu_we=1, with steal_cnt-1. A CPU read request gets no slot: no RAM access, cpu_ce stays 0 (CPU frozen with its address held).
  - WAIT exit: steal_cnt==0 at slot start goes to STEAL. vic_steal_req=0 at slot start returns to RUN and grants the slot.
  - STEAL: vic_aec=1, PHI2 used by the VIC, cpu_ce=0. vic_steal_req=0 at slot start returns to RUN (vic_aec=0) and grants that slot to the CPU.
- vic_steal_req is sampled only at PHI2 slot start; changes between slots have no effect until the next slot.
- STEAL_DELAY=0 goes straight RUN to STEAL at the next PHI2 slot.
- Simultaneous steal request and CPU write at RUN: the write completes and WAIT is entered.
- Address wrap: none; addresses pass through unmodified.

Decomposition:
- Shared package c64_bus_pkg:
  - Owner encoding OWN_NONE/OWN_CPU/OWN_VIC.
  - FSM state encoding RUN/WAIT/STEAL.
  - Defaults for AW, DW, STEAL_DELAY.
- Single module; no sub-module. Phase toggle, FSM and return mux are all small.

Test Plan:
1. Reset released; CPU reads $1300 holding $69 with vic_req=0 -> ram_ab=$1300 in PHI2; next clk cpu_di=$69, cpu_ce=1; vic_valid=0; cpu_ce never high in two consecutive clks.
2. CPU writes $27 to $0011 while the VIC reads $0400 holding $5A each PHI1 -> ram[$0011]=$27 after one PHI2; vic_di=$5A with vic_valid=1 in the clk after each PHI1; no conflict.
3. vic_steal_req=1 while the CPU issues 3 consecutive writes -> all 3 granted (WAIT), then STEAL, vic_aec=1, cpu_ce=0 and PHI2 ram_ab=vic_ab.
4. vic_steal_req=1 with the CPU reading -> no CPU slot in WAIT, cpu_ce=0, cpu_ab held; after 3 slots vic_aec=1; vic_steal_req=0 -> next PHI2 ram_ab=cpu_ab, read data returned, cpu_ce=1.
5. reset asserted in the clk after a CPU read slot -> outputs 0 immediately; no cpu_ce pulse and no vic_valid after release; phi restarts at PHI1.
6. STEAL_DELAY=0 build, vic_steal_req=1 -> vic_aec=1 at the very next PHI2 slot with no CPU grant.
